instr_gen: RTL
==============

INSTR_GEN -- requirements
Module: instr_gen

Interface
REQ-001 Parameters SHALL be declared as follows:
- DATA_WIDTH, default 32, width of din.
- BYTE_ADDR_WIDTH, default 8, byte-address bits.
- BANKS_ADDR_WIDTH, default 2, bank-select bits.
- BURST_LEN, default 4, instructions issued per burst.
- GAP_LEN, default 2, idle cycles inserted after each burst.
REQ-002 Define AW = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH; the parameter set SHALL satisfy AW <= 14, DATA_WIDTH >= AW, BURST_LEN >= 1 and GAP_LEN >= 0.
REQ-003 Ports SHALL be:
- clk, input, 1, the single clock; all logic is on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- start, input, 1, begins a run.
- seed_load, input, 1, loads seed into the LFSR.
- seed, input, 32, LFSR seed.
- num_instr, input, 16, number of valid instructions in the run.
- op_en, input, 3, allowed operations: [0]=write, [1]=read, [2]=move.
- hold, input, 1, downstream back-pressure.
- op, output, 2, operation: 00 none, 01 write, 10 read, 11 move.
- addr, output, AW, {bank, byte address}.
- din, output, DATA_WIDTH, write data or move destination.
- busy, output, 1, high in ISSUE or GAP.
- done, output, 1, high in DONE.
- issued, output, 16, valid instructions issued in the current run.
REQ-004 All outputs SHALL be driven from registers.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, GAP and DONE.
REQ-006 The LFSR SHALL be a 32-bit Galois LFSR, right-shifting, with mask 0x80200003: next = (s>>1) ^ (s[0] ? 0x80200003 : 0).
REQ-007 A seed value of 0 SHALL be loaded as 1.
REQ-008 The candidate instruction SHALL be formed from the current LFSR state s as follows:
- op = s[1:0].
- addr = s[AW+1:2].
- din for a write = s, zero-extended or truncated to DATA_WIDTH.
- din for a move = s[31:32-AW], zero-extended.
- din for a read = 0.
REQ-009 A candidate is valid when op != 00 and the op_en bit for that op is set.
REQ-010 On each edge in ISSUE with hold=0:
- The outputs SHALL register the candidate if valid, otherwise op, addr and din SHALL register as 0.
- The LFSR SHALL advance.
REQ-011 On each edge in ISSUE with hold=1:
- op, addr and din SHALL register as 0.
- The LFSR, remaining, burst and issued counters SHALL be frozen.
REQ-012 Each valid issue SHALL increment issued and burst and decrement remaining; invalid candidates SHALL not change these counters.
REQ-013 Transitions from ISSUE:
- When a valid issue makes remaining 0, the next state SHALL be DONE; DONE has priority over GAP.
- Otherwise, when burst reaches BURST_LEN, burst SHALL clear and the next state SHALL be GAP, or stay ISSUE if GAP_LEN = 0.
REQ-014 GAP SHALL last exactly GAP_LEN cycles, output op = 00 and ignore hold, then return to ISSUE.
REQ-015 In IDLE or DONE, start=1 SHALL perform all of the following:
- Load remaining ← num_instr.
- Clear issued and burst.
- Clear done.
- Enter ISSUE, or DONE if num_instr = 0.
REQ-016 The first candidate SHALL register on the edge after start is sampled.
REQ-017 seed_load SHALL act only in IDLE or DONE and SHALL be ignored in ISSUE and GAP.
REQ-018 When seed_load and start are asserted together, the first candidate SHALL be formed from the loaded seed.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 In IDLE and DONE, op, addr and din SHALL be held at 0.
REQ-021 issued SHALL hold its final value in DONE until the next start.
REQ-022 If op_en = 000, start SHALL be ignored.

Reset
REQ-023 rst=1 SHALL set the following at the edge, overriding all other inputs:
- state ← IDLE.
- LFSR ← 1.
- op, addr, din ← 0.
- busy, done ← 0.
- issued, remaining, burst ← 0.
REQ-024 rst=1 mid-run SHALL abort the run immediately, with no further instructions issued.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset; start with num_instr=2 and op_en=111 → first instruction write, addr=0, din=0x00000001; second instruction move, addr=0, din=0x00000200; then done=1, issued=2, op=00.
- num_instr=10, BURST_LEN=4, GAP_LEN=2, op_en=111, hold=0 → exactly 2 op=00 cycles after the 4th and 8th valid instructions; no gap after the 10th; issued=10.
- hold=1 for 3 cycles mid-burst → op=00 for those 3 cycles; the instruction sequence after release is identical to the hold-free run.
- op_en=010 (read only) → every non-zero op is 10 with din=0; rejected candidates appear as op=00 and are not counted.
- start with num_instr=0 → DONE on the next edge, with no instruction issued; start with op_en=000 → FSM stays IDLE.
- rst asserted in ISSUE after 3 instructions → next cycle: op=00, busy=0, issued=0, LFSR=1; seed_load with seed=0 → LFSR=1.

Source files
------------

// File: rtl/instr_gen.sv
// Pseudo-random memory instruction generator: a 32-bit Galois LFSR feeds
// write/read/move candidates that are issued in bursts separated by idle gaps.
module instr_gen #(
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_ADDR_WIDTH  = 8,
    parameter int BANKS_ADDR_WIDTH = 2,
    parameter int BURST_LEN        = 4,
    parameter int GAP_LEN          = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        seed_load,
    input  logic [31:0]                                 seed,
    input  logic [15:0]                                 num_instr,
    input  logic [2:0]                                  op_en,
    input  logic                                        hold,
    output logic [1:0]                                  op,
    output logic [BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]                       din,
    output logic                                        busy,
    output logic                                        done,
    output logic [15:0]                                 issued
);

    localparam int AW = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH;
    localparam logic [15:0] BURST_MAX = 16'(BURST_LEN);
    localparam logic [15:0] GAP_LAST  = (GAP_LEN > 0) ? 16'(GAP_LEN - 1) : 16'd0;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [15:0]     rem_q, rem_d;
    logic [15:0]     burst_q, burst_d;
    logic [15:0]     issued_q, issued_d;
    logic [15:0]     gap_q, gap_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [1:0]      cand_op;
    logic            cand_en;
    logic [DATA_WIDTH-1:0] cand_din;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    // Zero-extend or truncate a 32-bit value onto the data bus width.
    function automatic logic [DATA_WIDTH-1:0] fit_dw(input logic [31:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH && i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    always_comb begin
        cand_op  = lfsr_q[1:0];
        cand_en  = 1'b0;
        cand_din = '0;
        case (cand_op)
            2'b01: begin cand_en = op_en[0]; cand_din = fit_dw(lfsr_q); end
            2'b10: begin cand_en = op_en[1]; end
            2'b11: begin cand_en = op_en[2]; cand_din = fit_dw(32'(lfsr_q[31:32-AW])); end
            default: cand_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        rem_d    = rem_q;
        burst_d  = burst_q;
        issued_d = issued_q;
        gap_d    = gap_q;
        op_d     = 2'b00;
        addr_d   = '0;
        din_d    = '0;
        case (state_q)
            IDLE, DONE: begin
                if (seed_load) lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
                if (start && op_en != 3'b000) begin
                    rem_d    = num_instr;
                    issued_d = '0;
                    burst_d  = '0;
                    state_d  = (num_instr == 16'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cand_en) begin
                        op_d     = cand_op;
                        addr_d   = lfsr_q[AW+1:2];
                        din_d    = cand_din;
                        issued_d = issued_q + 16'd1;
                        rem_d    = rem_q - 16'd1;
                        burst_d  = burst_q + 16'd1;
                        // Finishing the run wins over closing the burst.
                        if (rem_q == 16'd1) begin
                            state_d = DONE;
                        end else if (burst_q + 16'd1 == BURST_MAX) begin
                            burst_d = '0;
                            gap_d   = '0;
                            if (GAP_LEN > 0) state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = ISSUE;
                else                   gap_d   = gap_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ISSUE) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= 32'h1;
            rem_q    <= '0;
            burst_q  <= '0;
            issued_q <= '0;
            gap_q    <= '0;
            op_q     <= 2'b00;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            rem_q    <= rem_d;
            burst_q  <= burst_d;
            issued_q <= issued_d;
            gap_q    <= gap_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign op     = op_q;
    assign addr   = addr_q;
    assign din    = din_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign issued = issued_q;

endmodule
